// File: rtl/tt_mux_ctrl_if.sv
// Select-request channel between the chip-level control block and tt_mux_ctrl.
// Ports: sel_valid/sel_ready handshake, sel_addr slot index, sel_none deselect-all qualifier.
// The master issues requests; the slave (tt_mux_ctrl) drives sel_ready.
interface tt_mux_ctrl_if #(
  parameter int ADDR_W = 3
) ();
  logic              sel_valid;
  logic              sel_ready;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_none;

  modport master (
    output sel_valid,
    output sel_addr,
    output sel_none,
    input  sel_ready
  );

  modport slave (
    input  sel_valid,
    input  sel_addr,
    input  sel_none,
    output sel_ready
  );
endinterface

// File: rtl/tt_mux_ctrl.sv
// Slot-select controller: break-before-make switch of per-slot ena, then a held-low rst_n pulse.
// Latency: accept at E -> ena all-zero from E+1, ena[target] after SETTLE_CYCLES, RUN after RST_CYCLES more.
// Backpressure: sel_ready is registered and low for the whole DRAIN/HOLD sequence; out-of-range requests only set err.
// Ports: clk, rst (async active-high); sel (slave side of the request channel);
//        ena (one-hot/zero slot enables), proj_rst_n (active slot reset), cur_addr/cur_valid (running slot),
//        busy (switch in progress), err (last accepted request was out of range).
module tt_mux_ctrl #(
  parameter int N_PROJ        = 8,
  parameter int ADDR_W        = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int RST_CYCLES    = 4
) (
  input  logic              clk,
  input  logic              rst,
  tt_mux_ctrl_if.slave      sel,
  output logic [N_PROJ-1:0] ena,
  output logic              proj_rst_n,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid,
  output logic              busy,
  output logic              err
);

  localparam int CNT_MAX = (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
  // The counter only ever holds (cycles - 1), so clog2(max) bits are enough.
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [N_PROJ-1:0] ONE = N_PROJ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] target;
  logic              pend_none;
  logic              ready_q;

  logic              accept;
  logic              addr_oor;
  logic [N_PROJ-1:0] target_onehot;

  assign sel.sel_ready  = ready_q;
  assign accept         = sel.sel_valid && ready_q;
  // Zero-extend before comparing so a full 2**ADDR_W array never trips this.
  assign addr_oor       = 32'(sel.sel_addr) >= 32'(N_PROJ);
  assign target_onehot  = ONE << target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      target     <= '0;
      pend_none  <= 1'b0;
      ready_q    <= 1'b1;
      ena        <= '0;
      proj_rst_n <= 1'b0;
      cur_addr   <= '0;
      cur_valid  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (accept) begin
            if (sel.sel_none) begin
              err <= 1'b0;
              // Deselect while idle has nothing to drain.
              if (state == RUN) begin
                pend_none  <= 1'b1;
                state      <= DRAIN;
                cnt        <= CNT_W'(SETTLE_CYCLES - 1);
                ena        <= '0;
                proj_rst_n <= 1'b0;
                cur_valid  <= 1'b0;
                busy       <= 1'b1;
                ready_q    <= 1'b0;
              end
            end else if (addr_oor) begin
              // Rejected in place: the running slot is left untouched.
              err <= 1'b1;
            end else begin
              // Re-selecting the running slot still drains: acts as a soft reset.
              err        <= 1'b0;
              target     <= sel.sel_addr;
              pend_none  <= 1'b0;
              state      <= DRAIN;
              cnt        <= CNT_W'(SETTLE_CYCLES - 1);
              ena        <= '0;
              proj_rst_n <= 1'b0;
              cur_valid  <= 1'b0;
              busy       <= 1'b1;
              ready_q    <= 1'b0;
            end
          end
        end

        DRAIN: begin
          if (cnt == '0) begin
            if (pend_none) begin
              state   <= IDLE;
              busy    <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              state <= HOLD;
              cnt   <= CNT_W'(RST_CYCLES - 1);
              ena   <= target_onehot;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        HOLD: begin
          if (cnt == '0) begin
            state      <= RUN;
            proj_rst_n <= 1'b1;
            cur_valid  <= 1'b1;
            cur_addr   <= target;
            busy       <= 1'b0;
            ready_q    <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state      <= IDLE;
          ena        <= '0;
          proj_rst_n <= 1'b0;
          cur_valid  <= 1'b0;
          busy       <= 1'b0;
          ready_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Randomized bench for tt_mux_ctrl with N_PROJ=6 so addresses 6 and 7 are out of range.
// The driver keeps a timeline model (time since the last switch accept) and queues expected outputs;
// a monitor pops one expectation per cycle and compares it against the DUT.
module tb_tt_mux_ctrl;

  localparam int N    = 6;
  localparam int AW   = 3;
  localparam int S    = 2;
  localparam int R    = 4;
  localparam int NCYC = 4000;

  typedef struct packed {
    logic [N-1:0]  ena;
    logic          rstn;
    logic          cv;
    logic [AW-1:0] ca;
    logic          busy;
    logic          err;
    logic          rdy;
  } obs_t;

  logic          clk;
  logic          rst;
  logic [N-1:0]  ena;
  logic          proj_rst_n;
  logic [AW-1:0] cur_addr;
  logic          cur_valid;
  logic          busy;
  logic          err;

  tt_mux_ctrl_if #(.ADDR_W(AW)) sel_if ();

  tt_mux_ctrl #(
    .N_PROJ(N), .ADDR_W(AW), .SETTLE_CYCLES(S), .RST_CYCLES(R)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel_if),
    .ena(ena), .proj_rst_n(proj_rst_n), .cur_addr(cur_addr),
    .cur_valid(cur_valid), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: a switch is described only by when it was accepted and where it goes.
  bit   have_sw = 1'b0;
  int   t_acc   = 0;
  int   tgt     = 0;     // -1 means deselect-all
  bit   err_m   = 1'b0;
  int   k       = 0;

  function automatic obs_t expect_now(int kk);
    obs_t         e;
    int           d;
    logic [N-1:0] one;
    one   = 1;
    e     = '0;
    e.rdy = 1'b1;
    e.err = err_m;
    if (have_sw) begin
      d = kk - t_acc;
      if (d <= S) begin
        e.busy = 1'b1;
        e.rdy  = 1'b0;
      end else if (tgt >= 0) begin
        e.ena = one << tgt;
        if (d <= S + R) begin
          e.busy = 1'b1;
          e.rdy  = 1'b0;
        end else begin
          e.rstn = 1'b1;
          e.cv   = 1'b1;
          e.ca   = AW'(tgt);
        end
      end
    end
    return e;
  endfunction

  // Driver + model
  initial begin
    obs_t last;
    int   rst_hold;
    logic v_d, n_d;
    int   a_d;

    rst              = 1'b1;
    rst_hold         = 2;
    sel_if.sel_valid = 1'b0;
    sel_if.sel_addr  = '0;
    sel_if.sel_none  = 1'b0;
    v_d  = 1'b0;
    n_d  = 1'b0;
    a_d  = 0;
    last = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      k++;
      // Effect of the edge that just happened.
      if (!rst && v_d && last.rdy) begin
        if (n_d) begin
          err_m = 1'b0;
          if (last.cv) begin
            have_sw = 1'b1;
            t_acc   = k - 1;
            tgt     = -1;
          end
        end else if (a_d >= N) begin
          err_m = 1'b1;
        end else begin
          err_m   = 1'b0;
          have_sw = 1'b1;
          t_acc   = k - 1;
          tgt     = a_d;
        end
      end
      // Reset: occasionally assert mid-sequence, hold 1..3 cycles.
      if (rst) begin
        if (rst_hold == 0) rst = 1'b0;
        else rst_hold--;
      end else if ($urandom_range(79) == 0) begin
        rst      = 1'b1;
        rst_hold = $urandom_range(2);
      end
      if (rst) begin
        have_sw = 1'b0;
        err_m   = 1'b0;
      end
      last = expect_now(k);
      exp_q.push_back(last);
      // Inputs for the next edge.
      v_d = ($urandom_range(3) == 0);
      a_d = $urandom_range(7);
      n_d = ($urandom_range(7) == 0);
      sel_if.sel_valid = v_d;
      sel_if.sel_addr  = AW'(a_d);
      sel_if.sel_none  = n_d;
    end

    #5;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Monitor
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #4;
      n_cmp++;
      if (!$onehot0(ena)) begin
        n_fail++;
        $display("FAIL onehot t=%0t: ena=%h has more than one bit set", $time, ena);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL underflow t=%0t: DUT output with no expectation queued", $time);
      end else begin
        e      = exp_q.pop_front();
        a.ena  = ena;
        a.rstn = proj_rst_n;
        a.cv   = cur_valid;
        a.ca   = e.cv ? cur_addr : '0;
        a.busy = busy;
        a.err  = err;
        a.rdy  = sel_if.sel_ready;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t: got ena=%h rstn=%b cv=%b ca=%0d busy=%b err=%b rdy=%b, want ena=%h rstn=%b cv=%b ca=%0d busy=%b err=%b rdy=%b",
                   $time, a.ena, a.rstn, a.cv, a.ca, a.busy, a.err, a.rdy,
                   e.ena, e.rstn, e.cv, e.ca, e.busy, e.err, e.rdy);
        end
      end
    end
  end

endmodule

// File: doc/tt_mux_ctrl.md
Name: tt_mux_ctrl

Overview:
- Slot-select controller for the tile's project array.
- Accepts select requests over a valid/ready handshake.
- Enforces a break-before-make sequence: all slot enables drop, a settle gap runs, the new slot's `ena` rises, then that slot's `rst_n` is held low for a fixed count before release.
- Sits between the chip-level control interface and the per-slot wrappers. It drives each wrapper's `ena` and supplies the `rst_n` bit that is packed into the wrapper's 18-bit input bus.

Parameters:
- N_PROJ, 8, number of project slots (1..256).
- ADDR_W, 3, width of slot address; must satisfy 2**ADDR_W >= N_PROJ.
- SETTLE_CYCLES, 2, cycles with all `ena` low between deselect and the new select (>=1).
- RST_CYCLES, 4, cycles the selected slot's `rst_n` is held low after its `ena` rises (>=1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sel_valid  input  1  request present.
- sel_ready  output  1  controller can accept a request.
- sel_addr  input  ADDR_W  requested slot index.
- sel_none  input  1  qualifies the request as "deselect all"; `sel_addr` is ignored.
- ena  output  N_PROJ  one-hot (or all-zero) per-slot enable.
- proj_rst_n  output  1  reset to the active slot, active-low.
- cur_addr  output  ADDR_W  index of the running slot; valid when `cur_valid` is high.
- cur_valid  output  1  a slot is in RUN.
- busy  output  1  switch sequence in progress (DRAIN or HOLD).
- err  output  1  sticky flag: the last accepted request had an out-of-range address.

Behaviour:

Reset (async assert, sync release):
- state=IDLE, ena=0, proj_rst_n=0, cur_addr=0, cur_valid=0, busy=0, err=0, sel_ready=1.

States:
- IDLE: no slot enabled. ena=0, proj_rst_n=0, sel_ready=1.
- DRAIN: ena=0, proj_rst_n=0, busy=1, sel_ready=0. Runs exactly SETTLE_CYCLES cycles. Then:
  - pending request is a deselect → IDLE;
  - otherwise → HOLD.
- HOLD: ena[target]=1, proj_rst_n=0, busy=1, sel_ready=0. Runs exactly RST_CYCLES cycles, then → RUN.
- RUN: ena[target]=1, proj_rst_n=1, cur_valid=1, cur_addr=target, sel_ready=1.

Handshake and acceptance:
- A request is accepted on a rising edge where sel_valid && sel_ready.
- sel_ready is a function of state only; it has no combinational path from sel_valid.
- Out-of-range accepted request (`sel_addr >= N_PROJ` and `sel_none=0`):
  - set err=1;
  - no state change; the current slot keeps running;
  - takes no cycles beyond the accept edge.
- In-range accepted request:
  - clear err, latch target;
  - next state is DRAIN, including when target equals the current slot (used as a soft reset).
- Deselect (`sel_none=1`) accepted in IDLE: stays in IDLE, clears err, no DRAIN.

Timing:
- Request accepted at edge E.
- ena is all-zero from E+1 and cur_valid=0 from E+1.
- ena[target] rises at E+1+SETTLE_CYCLES.
- proj_rst_n rises and cur_valid rises at E+1+SETTLE_CYCLES+RST_CYCLES.

Invariants:
- At most one `ena` bit is high at any time.
- `ena` never changes directly from one slot to another without at least SETTLE_CYCLES all-zero cycles.
- All outputs are registered.
- The counter is wide enough for max(SETTLE_CYCLES, RST_CYCLES). It reloads on every state entry and does not wrap within a state.
- Asserting rst in any state returns to the reset values immediately (asynchronously). The in-flight target is discarded.

Test Plan:
1. Reset, then request addr=3 at edge E → ena=0 through E+2; ena=8'h08 at E+3..E+6 with proj_rst_n=0; proj_rst_n=1, cur_valid=1, cur_addr=3 at E+7.
2. Running slot 3, request addr=5 → ena=8'h00 for exactly 2 cycles, then 8'h20; onehot0(ena) checked every cycle; sel_ready=0 throughout DRAIN/HOLD.
3. Running slot 5, request addr=5 → ena[5] low for 2 cycles, then rst_n low for 4 cycles, then RUN at addr 5.
4. N_PROJ=6, ADDR_W=3, running slot 2, request addr=7 → err=1, ena stays 8'h04, proj_rst_n stays 1; next request addr=1 clears err.
5. Running slot 1, deselect request → ena=0 after 1 cycle, IDLE after 2 cycles, cur_valid=0, proj_rst_n=0, sel_ready=1.
6. Assert rst during HOLD (second cycle) → same cycle ena=0, proj_rst_n=0, busy=0; after release, a request for addr=0 runs the full 1+2+4 sequence.
